// File: rtl/tinker_pkg.sv
// Shared constants and types for the tinker fetch unit.
// Widths, reset PC default, fetch FSM states and buffer entry layout.
package tinker_pkg;

  localparam int INST_W     = 32;
  localparam int ADDR_W     = 64;
  localparam int INST_BYTES = 4;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 64'h2000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/tinker_fetch_fifo.sv
// Instruction buffer: {pc, inst} entries with push, pop and flush.
// Head outputs read as zero while the buffer is empty.
module tinker_fetch_fifo
  import tinker_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wpc,
  input  logic [INST_W-1:0] winst,
  output logic [ADDR_W-1:0] rpc,
  output logic [INST_W-1:0] rinst,
  output logic [CW-1:0]     count
);

  fetch_entry_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic          nonempty;

  assign nonempty = (count != '0);
  assign do_push  = push & ~flush;
  assign do_pop   = pop & nonempty & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{pc: wpc, inst: winst};
  end

  assign rpc   = nonempty ? mem[rd_ptr].pc   : '0;
  assign rinst = nonempty ? mem[rd_ptr].inst : '0;

endmodule

// File: rtl/tinker_fetch.sv
// Tinker instruction fetch: PC, credit-limited memory requests,
// instruction buffer and redirect with stale-response draining.
module tinker_fetch
  import tinker_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] new_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     drop_nxt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit;
  logic              req_fire;
  logic              push;
  logic              pop;

  assign credit = {1'b0, fifo_count} + {1'b0, outstanding};

  // Buffered plus in-flight words never exceed DEPTH, so pushes always fit.
  assign mem_req_valid = ~reset & (state == FETCH)
                       & (credit < (CW+1)'(DEPTH));
  assign mem_req_addr  = pc;

  assign req_fire = mem_req_valid & mem_req_ready;
  assign inst_valid = (fifo_count != '0);
  assign pop  = inst_valid & inst_ready;
  assign push = mem_rsp_valid & (state == FETCH) & ~redirect_valid;

  assign outstanding_nxt = outstanding + CW'(req_fire)
                         - CW'(mem_rsp_valid);
  assign drop_nxt = drop - CW'(mem_rsp_valid);
  assign new_pc   = align_pc(redirect_pc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        pc     <= new_pc;
        rsp_pc <= new_pc;
        if (state == FETCH) begin
          drop  <= outstanding_nxt;
          state <= (outstanding_nxt != '0) ? DRAIN : FETCH;
        end else begin
          drop  <= drop_nxt;
          state <= (drop_nxt != '0) ? DRAIN : FETCH;
        end
      end else if (state == FETCH) begin
        if (req_fire)
          pc <= pc + ADDR_W'(INST_BYTES);
        if (mem_rsp_valid)
          rsp_pc <= rsp_pc + ADDR_W'(INST_BYTES);
      end else begin
        drop  <= drop_nxt;
        state <= (drop_nxt != '0) ? DRAIN : FETCH;
      end
    end
  end

  tinker_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wpc   (rsp_pc),
    .winst (mem_rsp_data),
    .rpc   (inst_pc),
    .rinst (instruction),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_tinker_fetch.sv
// Bench for tinker_fetch: directed scenarios plus random traffic
// against a transaction-level model of memory and instruction stream.
module tb_tinker_fetch;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h2000;

  logic        clk;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  tinker_fetch #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    bit          stale;
    int          due;
  } req_t;

  req_t        q[$];
  logic [63:0] bq[$];
  logic [63:0] next_addr;
  int cyc, last_due, total, bad;
  int p_mr, p_ir, lat_lo, lat_hi;
  int ndeliv, nreq, d0, r0;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (a[33:2] * 32'h0100_0193) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_addr", mem_req_addr, RPC);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_instruction", 64'(instruction), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    q.delete();
    bq.delete();
    next_addr = RPC;
    last_due = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: drive at negedge, check, then apply the cycle's events.
  task automatic step(input bit redir, input logic [63:0] rpc);
    bit   rv, mr, ir, draining, ev, req, pop;
    req_t e;
    int   due;
    mr = ($urandom_range(99) < p_mr);
    ir = ($urandom_range(99) < p_ir);
    rv = (q.size() > 0) && (q[0].due <= cyc);
    mem_rsp_valid = rv;
    mem_rsp_data = rv ? word_of(q[0].addr) : $urandom;
    mem_req_ready = mr;
    inst_ready = ir;
    redirect_valid = redir;
    redirect_pc = rpc;
    #1;
    draining = 0;
    foreach (q[i]) if (q[i].stale) draining = 1;
    ev = !draining && (q.size() + bq.size() < DEPTH);
    chk("req_valid", 64'(mem_req_valid), 64'(ev));
    if (ev) chk("req_addr", mem_req_addr, next_addr);
    chk("inst_valid", 64'(inst_valid), 64'(bq.size() > 0));
    if (bq.size() > 0) begin
      chk("inst_pc", inst_pc, bq[0]);
      chk("instruction", 64'(instruction), 64'(word_of(bq[0])));
    end
    req = ev && mr;
    pop = (bq.size() > 0) && ir;
    @(posedge clk);
    if (pop) begin
      void'(bq.pop_front());
      ndeliv++;
    end
    if (rv) begin
      e = q.pop_front();
      if (!e.stale && !redir) bq.push_back(e.addr);
    end
    if (req) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q.push_back('{next_addr, 1'b0, due});
      next_addr += 64'd4;
      nreq++;
    end
    if (redir) begin
      foreach (q[i]) q[i].stale = 1'b1;
      bq.delete();
      next_addr = {rpc[63:2], 2'b00};
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; ndeliv = 0; nreq = 0;
    p_mr = 100; p_ir = 100; lat_lo = 1; lat_hi = 1;
    do_reset();

    d0 = ndeliv;
    repeat (20) step(1'b0, '0);
    chk("throughput", 64'(ndeliv - d0), 64'd18);

    do_reset();
    p_ir = 0;
    r0 = nreq;
    repeat (10) step(1'b0, '0);
    chk("stall_reqs", 64'(nreq - r0), 64'(DEPTH));
    p_ir = 100;
    d0 = ndeliv;
    repeat (4) step(1'b0, '0);
    chk("stall_release", 64'(ndeliv - d0), 64'(DEPTH));
    repeat (6) step(1'b0, '0);

    do_reset();
    lat_lo = 3; lat_hi = 3;
    repeat (2) step(1'b0, '0);
    chk("drain_outstanding", 64'(q.size()), 64'd2);
    p_mr = 0;
    step(1'b1, 64'h3002);
    p_mr = 100;
    repeat (14) step(1'b0, '0);

    lat_lo = 1; lat_hi = 1;
    repeat (6) step(1'b0, '0);
    step(1'b1, 64'h5000);
    repeat (10) step(1'b0, '0);

    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (10) step(1'b0, '0);

    lat_lo = 3; lat_hi = 3;
    p_ir = 0;
    repeat (5) step(1'b0, '0);
    do_reset();
    p_ir = 100;
    lat_lo = 1; lat_hi = 1;
    repeat (6) step(1'b0, '0);

    for (int k = 0; k < 8; k++) begin
      p_mr = $urandom_range(100, 30);
      p_ir = $urandom_range(100, 20);
      lat_lo = 1;
      lat_hi = $urandom_range(4, 1);
      repeat (50) step($urandom_range(99) < 4, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tinker_fetch.md
# tinker_fetch

Instruction fetch unit that produces the 32-bit instruction stream consumed by `tinker_core`. It holds the program counter, issues in-order read requests to instruction memory over a valid/ready request channel, buffers returned words with their PCs in a small FIFO, and presents them to the decoder through a valid/ready handshake. A redirect port (branch/jump) flushes buffered and in-flight fetches and restarts at a new PC.

## Interface
- `RESET_PC`, default 64'h2000: PC of the first fetch after reset.
- `DEPTH`, default 4: instruction buffer entries (power of 2, ≥2); also bounds outstanding requests.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_req_valid`  out  1  read request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  64  byte address of the requested word, [1:0] always 0.
- `mem_rsp_valid`  in  1  response valid; in request order, ≥1 cycle after acceptance, no backpressure.
- `mem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  instruction available to decoder.
- `inst_ready`  in  1  decoder consumes instruction.
- `instruction`  out  32  instruction word (Tinker format: opcode[31:27], rd, rs, rt, L[11:0]).
- `inst_pc`  out  64  PC of `instruction`.
- `redirect_valid`  in  1  one-cycle request to restart fetch.
- `redirect_pc`  in  64  new PC; bits [1:0] ignored (treated as 0).

## Operation
- States: `FETCH`, `DRAIN`. Reset enters `FETCH`.
- `FETCH`: `mem_req_valid` = (fifo_count + outstanding < DEPTH). On request handshake: outstanding++, PC += 4 (wraps modulo 2^64).
- Response in `FETCH`: push {PC-of-request, data} into FIFO, outstanding--. Response PC tracked by a separate response-PC register advancing by 4 per accepted response.
- Credit rule guarantees FIFO never overflows; a response arriving with a full FIFO cannot occur.
- Decoder handshake (`inst_valid & inst_ready`) pops the FIFO head.
- Redirect (any state): PC and response-PC ← {redirect_pc[63:2],2'b00}; FIFO flushed; drop counter ← outstanding after this cycle's request/response accounting (a request accepted in the redirect cycle counts as stale; a response in the redirect cycle is dropped). Next state `DRAIN` if drop counter > 0, else `FETCH`.
- `DRAIN`: `mem_req_valid` = 0; each response is discarded and decrements drop counter and outstanding; → `FETCH` when drop counter reaches 0. A further redirect in `DRAIN` only updates PC; drop counter keeps counting.
- An instruction popped in the redirect cycle is considered delivered.
- Simultaneous push and pop: both take effect; count unchanged.

## Timing
- Reset values: `mem_req_valid`=0, `mem_req_addr`=RESET_PC, `inst_valid`=0, `instruction`=0, `inst_pc`=0, outstanding=0, FIFO empty, state `FETCH`.
- First cycle after reset deassertion: `mem_req_valid`=1, `mem_req_addr`=RESET_PC.
- `mem_req_valid`/`mem_req_addr` depend only on registered state and `redirect_valid`-free state; no combinational path from `mem_req_ready`. Once asserted, valid and addr hold until accepted unless a redirect occurs.
- Response in cycle r → `inst_valid` high in cycle r+1 (no bypass). Request accepted cycle n with 1-cycle memory → instruction visible at n+2.
- Full throughput: one instruction per cycle with single-cycle memory and `inst_ready` held high.
- Reset mid-operation: all state cleared immediately; memory must be reset concurrently (no post-reset responses for pre-reset requests).

## Structure
- `tinker_pkg`: `INST_W`=32, `ADDR_W`=64, `INST_BYTES`=4, default `RESET_PC`, enum `fetch_state_t {FETCH, DRAIN}`.
- Sub-module `tinker_fetch_fifo`: synchronous FIFO of {pc[63:0], inst[31:0]}, DEPTH entries, push/pop/flush, count output.

## Test plan
- Reset, `mem_req_ready`=1, 1-cycle memory returning addr-derived words, `inst_ready`=1 → PCs 0x2000, 0x2004, 0x2008… delivered one per cycle, first at cycle 2.
- `inst_ready`=0 for 10 cycles → exactly DEPTH=4 requests issued, `mem_req_valid` drops, no data lost; release → 4 words in order.
- 3-cycle memory latency, redirect to 0x3002 with 2 requests outstanding → `DRAIN`, 2 responses dropped, next request addr 0x3000, `inst_pc` 0x3000 first.
- Redirect in same cycle as request handshake and response → both counted stale/dropped; no stale PC ever reaches decoder.
- Redirect to 64'hFFFF_FFFF_FFFF_FFFC → next fetches 0xFFFF_FFFF_FFFF_FFFC, then 0x0.
- Assert `reset` with FIFO full and requests outstanding → all outputs at reset values same cycle; restart at 0x2000.
